// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder walks the operands LSB first, one bit per clock.
// Optional SERIAL_ADDER_SUB_EN macro adds a 'sub' input that turns the block into op_a - op_b.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d, cout_q, cout_d;
   logic [WIDTH-1:0] b_load;
   logic             c_load;
   logic             fa_a, fa_b, fa_s, fa_c;

   // Subtraction is a + ~b + 1, so it folds into what gets latched at start.
`ifdef SERIAL_ADDER_SUB_EN
   assign b_load = op_b ^ {WIDTH{sub}};
   assign c_load = cin | sub;
`else
   assign b_load = op_b;
   assign c_load = cin;
`endif

   assign fa_a = a_q[cnt_q];
   assign fa_b = b_q[cnt_q];
   assign fa_s = fa_a ^ fa_b ^ carry_q;
   assign fa_c = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ready   = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               a_d     = op_a;
               b_d     = b_load;
               carry_d = c_load;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[cnt_q] = fa_s;
            carry_d      = fa_c;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cout_d  = fa_c;
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench: an 8-bit instance for directed/random ops and a 2-bit instance for an exhaustive sweep.
module tb_serial_adder_ctrl;

   typedef struct {
      logic [8:0] res;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst8, start8, cin8, sub8, ready8, cout8, done8;
   logic [7:0] op_a8, op_b8, sum8;
   logic       rst2, start2, cin2, sub2, ready2, cout2, done2;
   logic [1:0] op_a2, op_b2, sum2;

   exp_t q8[$];
   exp_t q2[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .op_a(op_a8), .op_b(op_b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub8),
`endif
      .ready(ready8), .sum(sum8), .cout(cout8), .done(done8));

   serial_adder_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .op_a(op_a2), .op_b(op_b2), .cin(cin2),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub2),
`endif
      .ready(ready2), .sum(sum2), .cout(cout2), .done(done2));

   // Reference: plain integer arithmetic on the (w+1)-bit result {cout,sum}.
   function automatic logic [8:0] model(int a, int b, int c, int s, int w);
      int r;
      if (s != 0) r = a - b + (1 << w);
      else        r = a + b + c;
      return 9'(r % (1 << (w + 1)));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (done8 === 1'b1) begin
         if (q8.size() == 0) begin
            total++; bad++;
            $display("FAIL done8_spurious: got done with sum %0h expected no done (cyc %0d)", sum8, cyc);
         end else begin
            e = q8.pop_front();
            chk("sum8", 32'(sum8), 32'(e.res[7:0]));
            chk("cout8", 32'(cout8), 32'(e.res[8]));
            chk("lat8", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (done2 === 1'b1) begin
         if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL done2_spurious: got done with sum %0h expected no done (cyc %0d)", sum2, cyc);
         end else begin
            e = q2.pop_front();
            chk("sum2", 32'(sum2), 32'(e.res[1:0]));
            chk("cout2", 32'(cout2), 32'(e.res[2]));
            chk("lat2", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; start is sampled on the next posedge once ready.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s,
                         input bit push);
      int g = 0;
      while (ready8 !== 1'b1 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (ready8 !== 1'b1) begin
         total++; bad++;
         $display("FAIL ready8_timeout: got ready %b expected 1", ready8);
      end
      op_a8 = a; op_b8 = b; cin8 = c; sub8 = s; start8 = 1'b1;
      if (push) q8.push_back('{model(a, b, c, s, 8), cyc + 1 + 8});
      @(negedge clk);
      start8 = 1'b0;
      op_a8 = 8'($urandom); op_b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
   endtask

   task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic c, input logic s);
      int g = 0;
      while (ready2 !== 1'b1 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (ready2 !== 1'b1) begin
         total++; bad++;
         $display("FAIL ready2_timeout: got ready %b expected 1", ready2);
      end
      op_a2 = a; op_b2 = b; cin2 = c; sub2 = s; start2 = 1'b1;
      q2.push_back('{model(a, b, c, s, 2), cyc + 1 + 2});
      @(negedge clk);
      start2 = 1'b0;
      op_a2 = 2'($urandom); op_b2 = 2'($urandom); cin2 = 1'($urandom); sub2 = 1'($urandom);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic s;
      rst8 = 1'b1; rst2 = 1'b1;
      start8 = 1'b0; op_a8 = '0; op_b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      start2 = 1'b0; op_a2 = '0; op_b2 = '0; cin2 = 1'b0; sub2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_sum", 32'(sum8), 32'h0);
      chk("rst_cout", 32'(cout8), 32'h0);
      chk("rst_done", 32'(done8), 32'h0);
      chk("rst_ready", 32'(ready8), 32'h1);
      chk("rst_ready2", 32'(ready2), 32'h1);
      rst8 = 1'b0; rst2 = 1'b0;

      issue8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);

      issue8(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
      chk("busy_ready", 32'(ready8), 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("busy_ready", 32'(ready8), 32'h0);
      end
      @(negedge clk);
      chk("idle_ready", 32'(ready8), 32'h1);

      // A second start while running must be dropped entirely.
      issue8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
      start8 = 1'b1; op_a8 = 8'hFF; op_b8 = 8'hFF; cin8 = 1'b1;
      repeat (3) @(negedge clk);
      start8 = 1'b0;

      issue8(8'($urandom), 8'($urandom), 1'b1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst8 = 1'b1;
      #1;
      chk("abort_sum", 32'(sum8), 32'h0);
      chk("abort_cout", 32'(cout8), 32'h0);
      chk("abort_done", 32'(done8), 32'h0);
      chk("abort_ready", 32'(ready8), 32'h1);
      @(negedge clk);
      rst8 = 1'b0;
      issue8(8'hAA, 8'h55, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
      issue8(8'h05, 8'h07, 1'b0, 1'b1, 1'b1);
      issue8(8'h07, 8'h05, 1'b0, 1'b1, 1'b1);
`endif

      for (int i = 0; i < 60; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         issue8(8'($urandom), 8'($urandom), 1'($urandom), s, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 2; c++)
               issue2(2'(a), 2'(b), 1'(c), 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            issue2(2'(a), 2'(b), 1'b0, 1'b1);
`endif

      repeat (20) @(negedge clk);
      chk("q8_drained", 32'(q8.size()), 32'h0);
      chk("q2_drained", 32'(q2.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
